hicore_fetch: RTL and testbench

Instruction fetch stage of the HiCore RV32 core. It owns the architectural fetch PC and issues word requests to instruction memory over a valid/ready handshake. Returned instructions are buffered in a small in-order queue and presented to decode together with their PC. It consumes the execute-stage redirect (branch, branch_pc): on a redirect it flushes the queue, discards in-flight responses and restarts fetch at the new target.

---
 rtl/hicore_fetch_pkg.sv | 25 ++
 rtl/hicore_fetch_fifo.sv | 68 ++++++
 rtl/hicore_fetch.sv | 125 ++++++++++++
 tb/tb_hicore_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hicore_fetch_pkg.sv
// rtl/hicore_fetch_pkg.sv - HiCore core configuration and fetch queue entry layout
// Contents: PC/register widths, the instruction-queue entry struct and the
// sequential-PC helper shared by the fetch stage.
package hicore_fetch_pkg;

  localparam int HiCore_PC_SIZE  = 32;
  localparam int HiCore_REG_SIZE = 32;

  // One decoded-side queue entry: where it came from, what came back, and
  // which of the two fetch faults (if any) it carries.
  typedef struct packed {
    logic [HiCore_PC_SIZE-1:0]  pc;
    logic [HiCore_REG_SIZE-1:0] instr;
    logic                       err;
    logic                       misalign;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  // Next sequential fetch address; wraps naturally at 2^32.
  function automatic logic [HiCore_PC_SIZE-1:0] pc_next(input logic [HiCore_PC_SIZE-1:0] pc);
    return pc + HiCore_PC_SIZE'(4);
  endfunction

endpackage

// File: rtl/hicore_fetch_fifo.sv
// rtl/hicore_fetch_fifo.sv - DEPTH-entry FIFO with synchronous flush
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop all entries this edge (wins over push/pop)
//   push, push_data write an entry
//   pop             consume the head entry (ignored when empty)
//   head            current head entry, combinational from storage
//   count           number of valid entries
module hicore_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO may still accept a write when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  // Callers size their credits so a write into a full FIFO never happens.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !do_push)) else $error("hicore_fetch_fifo overflow");
    end
  end

endmodule

// File: rtl/hicore_fetch.sv
// rtl/hicore_fetch.sv - HiCore RV32 instruction fetch stage
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   branch, branch_pc         execute-stage redirect strobe and target
//   ifu_req_valid/ready/addr  word fetch request to instruction memory
//   ifu_rsp_valid/instr/err   in-order memory response, always accepted
//   if_valid/ready            head entry handshake with decode
//   if_pc/instr/err/misalign  head entry contents (zero when no entry)
module hicore_fetch
  import hicore_fetch_pkg::*;
#(
  parameter logic [HiCore_PC_SIZE-1:0] RESET_PC = 32'h0000_0000,
  parameter int                        DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch,
  input  logic [HiCore_PC_SIZE-1:0]  branch_pc,
  output logic                       ifu_req_valid,
  input  logic                       ifu_req_ready,
  output logic [HiCore_PC_SIZE-1:0]  ifu_req_addr,
  input  logic                       ifu_rsp_valid,
  input  logic [HiCore_REG_SIZE-1:0] ifu_rsp_instr,
  input  logic                       ifu_rsp_err,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [HiCore_PC_SIZE-1:0]  if_pc,
  output logic [HiCore_REG_SIZE-1:0] if_instr,
  output logic                       if_err,
  output logic                       if_misalign
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [HiCore_PC_SIZE-1:0] pc;
  logic [CW-1:0]             drop_cnt;
  logic                      halt;
  logic                      mis_pend;

  logic [HiCore_PC_SIZE-1:0] tag_pc;
  logic [CW-1:0]             tag_count;
  logic [CW-1:0]             iq_count;
  logic [CW:0]               outstanding;
  logic                      req_fire;
  logic                      rsp_keep;
  logic                      rsp_drop;
  iq_entry_t                 iq_push_data;
  iq_entry_t                 iq_head;
  iq_entry_t                 shown;

  // The tag FIFO holds exactly the live (not-to-be-dropped) in-flight
  // requests, so total in-flight is its occupancy plus the drop backlog.
  assign outstanding = {1'b0, tag_count} + {1'b0, drop_cnt};

  assign ifu_req_valid = ~rst & ~branch & ~halt &
                         ((outstanding + {1'b0, iq_count}) < (CW+1)'(DEPTH));
  assign ifu_req_addr  = pc;
  assign req_fire      = ifu_req_valid & ifu_req_ready;
  assign rsp_drop      = ifu_rsp_valid & (drop_cnt != '0);
  assign rsp_keep      = ifu_rsp_valid & (drop_cnt == '0);

  // After a misaligned redirect everything in flight is being dropped and
  // fetch is halted, so the fault entry never competes with a response.
  always_comb begin
    iq_push_data = '0;
    if (mis_pend) begin
      iq_push_data.pc       = pc;
      iq_push_data.misalign = 1'b1;
    end else begin
      iq_push_data.pc    = tag_pc;
      iq_push_data.instr = ifu_rsp_instr;
      iq_push_data.err   = ifu_rsp_err;
    end
  end

  hicore_fetch_fifo #(.WIDTH(HiCore_PC_SIZE), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .head      (tag_pc),
    .count     (tag_count)
  );

  hicore_fetch_fifo #(.WIDTH(IQ_ENTRY_W), .DEPTH(DEPTH)) u_iq (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch),
    .push      (mis_pend | rsp_keep),
    .push_data (iq_push_data),
    .pop       (if_ready),
    .head      (iq_head),
    .count     (iq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
      halt     <= 1'b0;
      mis_pend <= 1'b0;
    end else if (branch) begin
      // A response landing in the redirect cycle is already consumed, so it
      // is not part of the new drop backlog.
      pc       <= branch_pc;
      drop_cnt <= CW'(outstanding - (CW+1)'(ifu_rsp_valid));
      halt     <= |branch_pc[1:0];
      mis_pend <= |branch_pc[1:0];
    end else begin
      mis_pend <= 1'b0;
      if (req_fire) pc <= pc_next(pc);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  assign if_valid    = ~rst & (iq_count != '0);
  assign shown       = if_valid ? iq_head : '0;
  assign if_pc       = shown.pc;
  assign if_instr    = shown.instr;
  assign if_err      = shown.err;
  assign if_misalign = shown.misalign;

endmodule

// File: tb/tb_hicore_fetch.sv
// tb/tb_hicore_fetch.sv - directed self-checking bench for hicore_fetch
module tb_hicore_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b1;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_instr = '0;
  logic        ifu_rsp_err = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_err;
  logic        if_misalign;

  always #5 clk = ~clk;

  hicore_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .branch_pc     (branch_pc),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_instr (ifu_rsp_instr),
    .ifu_rsp_err   (ifu_rsp_err),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_err        (if_err),
    .if_misalign   (if_misalign)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    logic        mis;
  } ent_t;

  ent_t        log_q[$];
  logic [31:0] pend[$];
  logic        rsp_en = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc, hs_cnt, first_req, first_val;
  int          n0, n1, hs0;
  logic        found;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: sample at the falling edge, model memory after the rising edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    cyc++;
    if (ifu_rsp_valid) void'(pend.pop_front());
    if (ifu_req_valid && ifu_req_ready) begin
      hs_cnt++;
      if (first_req < 0) first_req = cyc;
      pend.push_back(ifu_req_addr);
    end
    if (if_valid && first_val < 0) first_val = cyc;
    if (if_valid && if_ready) begin
      e.pc = if_pc; e.instr = if_instr; e.err = if_err; e.mis = if_misalign;
      log_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rsp_en && pend.size() > 0) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = mk(pend[0]);
      ifu_rsp_err   = err_en && (pend[0] == err_addr);
    end else begin
      ifu_rsp_valid = 1'b0;
      ifu_rsp_instr = '0;
      ifu_rsp_err   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch = 1'b0;
    rsp_en = 1'b1;
    if_ready = 1'b1;
    pend.delete();
    ifu_rsp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    log_q.delete();
    cyc = 0; hs_cnt = 0; first_req = -1; first_val = -1;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    check("rst_req_valid", ifu_req_valid, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    do_reset();
    check("rst_pc", ifu_req_addr, 32'h0);
    check("rst_release_req", ifu_req_valid, 1);

    // Sequential fetch and latency
    ticks(12);
    check("seq_count", log_q.size() >= 4, 1);
    check("seq_pc0", log_q[0].pc, 32'h0);
    check("seq_pc1", log_q[1].pc, 32'h4);
    check("seq_pc2", log_q[2].pc, 32'h8);
    check("seq_pc3", log_q[3].pc, 32'hC);
    check("seq_instr0", log_q[0].instr, mk(32'h0));
    check("seq_latency", first_val - first_req, 2);

    // Decode stall bounds the number of requests
    do_reset();
    if_ready = 1'b0;
    ticks(10);
    check("stall_reqs", hs_cnt, 2);
    check("stall_req_valid", ifu_req_valid, 0);
    check("stall_head_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    ticks(6);
    check("stall_count", log_q.size() >= 3, 1);
    check("stall_pc0", log_q[0].pc, 32'h0);
    check("stall_pc1", log_q[1].pc, 32'h4);
    check("stall_pc2", log_q[2].pc, 32'h8);

    // Redirect with two requests in flight
    do_reset();
    rsp_en = 1'b0;
    ticks(3);
    check("redir_inflight", hs_cnt, 2);
    branch = 1'b1; branch_pc = 32'h100;
    tick();
    branch = 1'b0;
    rsp_en = 1'b1;
    ticks(10);
    check("redir_count", log_q.size() >= 2, 1);
    check("redir_pc0", log_q[0].pc, 32'h100);
    check("redir_pc1", log_q[1].pc, 32'h104);
    check("redir_instr0", log_q[0].instr, mk(32'h100));

    // Redirect coinciding with a response and a decode pop
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (if_valid && ifu_rsp_valid) found = 1'b1;
    end
    check("coinc_setup", found, 1);
    branch = 1'b1; branch_pc = 32'h300;
    tick();
    branch = 1'b0;
    check("coinc_flush", if_valid, 0);
    n0 = log_q.size();
    ticks(8);
    check("coinc_count", log_q.size() >= n0 + 2, 1);
    check("coinc_pc0", log_q[n0].pc, 32'h300);
    check("coinc_pc1", log_q[n0+1].pc, 32'h304);

    // Misaligned redirect halts fetch until an aligned redirect
    do_reset();
    ticks(3);
    branch = 1'b1; branch_pc = 32'h102;
    tick();
    branch = 1'b0;
    n0 = log_q.size();
    hs0 = hs_cnt;
    ticks(8);
    check("mis_no_fetch", hs_cnt - hs0, 0);
    check("mis_one_entry", log_q.size() - n0, 1);
    check("mis_pc", log_q[n0].pc, 32'h102);
    check("mis_flag", log_q[n0].mis, 1);
    check("mis_instr", log_q[n0].instr, 32'h0);
    branch = 1'b1; branch_pc = 32'h200;
    tick();
    branch = 1'b0;
    n1 = log_q.size();
    ticks(6);
    check("mis_resume_count", log_q.size() >= n1 + 1, 1);
    check("mis_resume_pc", log_q[n1].pc, 32'h200);
    check("mis_resume_flag", log_q[n1].mis, 0);

    // Bus error forwarded with its PC
    do_reset();
    err_en = 1'b1; err_addr = 32'h8;
    ticks(12);
    check("err_count", log_q.size() >= 3, 1);
    check("err_pc", log_q[2].pc, 32'h8);
    check("err_flag", log_q[2].err, 1);
    check("err_prev_clean", log_q[1].err, 0);
    check("err_instr", log_q[2].instr, mk(32'h8));
    err_en = 1'b0;

    // Redirect gates requests combinationally; PC wraps past 0xFFFF_FFFC
    do_reset();
    branch = 1'b1; branch_pc = 32'hFFFF_FFFC;
    #1;
    check("br_gates_req", ifu_req_valid, 0);
    tick();
    branch = 1'b0;
    check("wrap_addr0", ifu_req_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", ifu_req_addr, 32'h0);
    ticks(8);
    check("wrap_count", log_q.size() >= 2, 1);
    check("wrap_pc0", log_q[0].pc, 32'hFFFF_FFFC);
    check("wrap_pc1", log_q[1].pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
